// File: rtl/cr_xp10_decomp_im_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cr_xp10_decomp_im_arb_pkg : shared types for the IM write-port arbiter   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cr_xp10_decomp_im_arb_pkg;

  localparam int IM_N_SRC = 3;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } im_bank_state_e;

  typedef enum logic [1:0] {
    IM_SRC_XPD    = 2'd0,
    IM_SRC_LZ77D  = 2'd1,
    IM_SRC_HTF_BL = 2'd2
  } im_src_e;

  // (base + off) mod 3 for 2-bit source indices
  function automatic logic [1:0] rr_rot(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cr_xp10_decomp_im_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cr_xp10_decomp_im_arb_if : capture sources, IM write, avail/consume bus  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface cr_xp10_decomp_im_arb_if
  import cr_xp10_decomp_im_arb_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int IM_DEPTH = 512
);
  localparam int AW = $clog2(IM_DEPTH);

  logic                         enable;
  logic [IM_N_SRC-1:0]          src_valid;
  logic [IM_N_SRC-1:0]          src_last;
  logic [IM_N_SRC*DATA_W-1:0]   src_data;
  logic [IM_N_SRC-1:0]          src_ready;

  logic                         im_wr_en;
  logic [1:0]                   im_wr_src;
  logic                         im_wr_bank;
  logic [AW-1:0]                im_wr_addr;
  logic [DATA_W-1:0]            im_wr_data;

  logic                         im_avail_valid;
  logic [1:0]                   im_avail_src;
  logic                         im_avail_bank;
  logic [AW:0]                  im_avail_count;

  logic                         im_consumed_valid;
  logic [1:0]                   im_consumed_src;
  logic                         im_consumed_bank;
  logic                         err_bad_consume;

  modport master (
    output enable, src_valid, src_last, src_data,
    output im_consumed_valid, im_consumed_src, im_consumed_bank,
    input  src_ready,
    input  im_wr_en, im_wr_src, im_wr_bank, im_wr_addr, im_wr_data,
    input  im_avail_valid, im_avail_src, im_avail_bank, im_avail_count,
    input  err_bad_consume
  );

  modport slave (
    input  enable, src_valid, src_last, src_data,
    input  im_consumed_valid, im_consumed_src, im_consumed_bank,
    output src_ready,
    output im_wr_en, im_wr_src, im_wr_bank, im_wr_addr, im_wr_data,
    output im_avail_valid, im_avail_src, im_avail_bank, im_avail_count,
    output err_bad_consume
  );
endinterface
`default_nettype wire

// File: rtl/cr_xp10_decomp_im_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cr_xp10_decomp_im_rr_arb : 3-way round-robin arbiter, registered pointer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cr_xp10_decomp_im_rr_arb
  import cr_xp10_decomp_im_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [IM_N_SRC-1:0] req,
  output logic [IM_N_SRC-1:0] gnt
);

  logic [1:0] rr_q;
  logic [1:0] rr_d;

  // First requester at or after rr wins; rr then moves just past the winner.
  always_comb begin
    gnt  = '0;
    rr_d = rr_q;
    for (int k = 0; k < IM_N_SRC; k++) begin
      if (gnt == '0 && req[rr_rot(rr_q, k[1:0])]) begin
        gnt[rr_rot(rr_q, k[1:0])] = 1'b1;
        rr_d = rr_rot(rr_q, k[1:0] + 2'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 2'd0;
    else     rr_q <= rr_d;
  end

endmodule
`default_nettype wire

// File: rtl/cr_xp10_decomp_im_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cr_xp10_decomp_im_arb : shares one IM write port among three sources     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cr_xp10_decomp_im_arb
  import cr_xp10_decomp_im_arb_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int IM_DEPTH = 512
)(
  input  logic                     clk,
  input  logic                     rst,
  cr_xp10_decomp_im_arb_if.slave   bus
);
  localparam int AW = $clog2(IM_DEPTH);

  im_bank_state_e      bank_state_q [IM_N_SRC][2];
  im_bank_state_e      bank_state_d [IM_N_SRC][2];
  logic [IM_N_SRC-1:0] cur_bank_q, cur_bank_d;
  logic [AW-1:0]       wptr_q [IM_N_SRC];
  logic [AW-1:0]       wptr_d [IM_N_SRC];

  logic                wr_en_q,  wr_en_d;
  logic [1:0]          wr_src_q, wr_src_d;
  logic                wr_bank_q, wr_bank_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                avail_q, avail_d;
  logic [1:0]          avail_src_q, avail_src_d;
  logic                avail_bank_q, avail_bank_d;
  logic [AW:0]         avail_count_q, avail_count_d;
  logic                err_q, err_d;

  logic [IM_N_SRC-1:0] w_req;
  logic [IM_N_SRC-1:0] w_gnt;
  logic [1:0]          w_gidx;
  logic                w_xfer;
  logic                w_done;
  logic [DATA_W-1:0]   w_src_word [IM_N_SRC];

  for (genvar i = 0; i < IM_N_SRC; i++) begin : g_src
    assign w_src_word[i] = bus.src_data[i*DATA_W +: DATA_W];
    assign w_req[i] = bus.enable & bus.src_valid[i] &
                      (bank_state_q[i][cur_bank_q[i]] != FULL);
  end

  cr_xp10_decomp_im_rr_arb u_rr_arb (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .gnt (w_gnt)
  );

  assign bus.src_ready = w_gnt;
  assign w_gidx = w_gnt[2] ? 2'd2 : (w_gnt[1] ? 2'd1 : 2'd0);
  assign w_xfer = |w_gnt;
  assign w_done = bus.src_last[w_gidx] | (wptr_q[w_gidx] == AW'(IM_DEPTH - 1));

  always_comb begin
    bank_state_d  = bank_state_q;
    cur_bank_d    = cur_bank_q;
    wptr_d        = wptr_q;
    wr_en_d       = w_xfer;
    wr_src_d      = w_xfer ? w_gidx : 2'd0;
    wr_bank_d     = w_xfer & cur_bank_q[w_gidx];
    wr_addr_d     = w_xfer ? wptr_q[w_gidx] : '0;
    wr_data_d     = w_xfer ? w_src_word[w_gidx] : '0;
    avail_d       = w_xfer & w_done;
    avail_src_d   = avail_d ? w_gidx : 2'd0;
    avail_bank_d  = avail_d & cur_bank_q[w_gidx];
    avail_count_d = avail_d ? ({1'b0, wptr_q[w_gidx]} + (AW+1)'(1)) : '0;
    err_d         = 1'b0;

    // A release can only hit a FULL bank and a write never does, so the two never collide.
    if (bus.im_consumed_valid) begin
      if (bus.im_consumed_src != 2'd3 &&
          bank_state_q[bus.im_consumed_src][bus.im_consumed_bank] == FULL)
        bank_state_d[bus.im_consumed_src][bus.im_consumed_bank] = FREE;
      else
        err_d = 1'b1;
    end

    if (w_xfer) begin
      if (w_done) begin
        bank_state_d[w_gidx][cur_bank_q[w_gidx]] = FULL;
        wptr_d[w_gidx]     = '0;
        cur_bank_d[w_gidx] = ~cur_bank_q[w_gidx];
      end else begin
        bank_state_d[w_gidx][cur_bank_q[w_gidx]] = FILLING;
        wptr_d[w_gidx]     = wptr_q[w_gidx] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IM_N_SRC; i++) begin
        bank_state_q[i][0] <= FREE;
        bank_state_q[i][1] <= FREE;
        wptr_q[i]          <= '0;
      end
      cur_bank_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_src_q      <= 2'd0;
      wr_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      avail_q       <= 1'b0;
      avail_src_q   <= 2'd0;
      avail_bank_q  <= 1'b0;
      avail_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      bank_state_q  <= bank_state_d;
      wptr_q        <= wptr_d;
      cur_bank_q    <= cur_bank_d;
      wr_en_q       <= wr_en_d;
      wr_src_q      <= wr_src_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      avail_q       <= avail_d;
      avail_src_q   <= avail_src_d;
      avail_bank_q  <= avail_bank_d;
      avail_count_q <= avail_count_d;
      err_q         <= err_d;
    end
  end

  assign bus.im_wr_en        = wr_en_q;
  assign bus.im_wr_src       = wr_src_q;
  assign bus.im_wr_bank      = wr_bank_q;
  assign bus.im_wr_addr      = wr_addr_q;
  assign bus.im_wr_data      = wr_data_q;
  assign bus.im_avail_valid  = avail_q;
  assign bus.im_avail_src    = avail_src_q;
  assign bus.im_avail_bank   = avail_bank_q;
  assign bus.im_avail_count  = avail_count_q;
  assign bus.err_bad_consume = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cr_xp10_decomp_im_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cr_xp10_decomp_im_arb : directed + random bench with reference model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cr_xp10_decomp_im_arb;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cr_xp10_decomp_im_arb_if #(.DATA_W(DW), .IM_DEPTH(DEPTH)) bus ();

  cr_xp10_decomp_im_arb #(.DATA_W(DW), .IM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = free, 1 = filling, 2 = full
  int m_st [3][2];
  int m_cb [3];
  int m_wp [3];
  int m_rr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i][0] = 0;
      m_st[i][1] = 0;
      m_cb[i]    = 0;
      m_wp[i]    = 0;
    end
    m_rr = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.src_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(bus.im_wr_en), 64'd0);
    check({tag, "_wr_fields"},
          64'({bus.im_wr_src, bus.im_wr_bank, bus.im_wr_addr, bus.im_wr_data}), 64'd0);
    check({tag, "_avail"},
          64'({bus.im_avail_valid, bus.im_avail_src, bus.im_avail_bank, bus.im_avail_count}), 64'd0);
    check({tag, "_err"}, 64'(bus.err_bad_consume), 64'd0);
  endtask

  task automatic idle_inputs();
    bus.enable            = 1'b0;
    bus.src_valid         = 3'b000;
    bus.src_last          = 3'b000;
    bus.src_data          = '0;
    bus.im_consumed_valid = 1'b0;
    bus.im_consumed_src   = 2'd0;
    bus.im_consumed_bank  = 1'b0;
  endtask

  // Asynchronous reset, raised between clock edges
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_outputs_zero("reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cycle(input logic en, input logic [2:0] v, input logic [2:0] l,
                       input logic cv, input logic [1:0] cs, input logic cbk);
    logic [63:0] r;
    logic [63:0] sh;
    logic [2:0]  e_ready;
    int          g;
    int          i;
    bit          done;
    bit          e_wr, e_av, e_err;
    int          e_src, e_bank, e_addr, e_cnt;
    logic [DW-1:0] e_data;

    r = {$urandom(), $urandom()};
    bus.enable            = en;
    bus.src_valid         = v;
    bus.src_last          = l;
    bus.src_data          = r[3*DW-1:0];
    bus.im_consumed_valid = cv;
    bus.im_consumed_src   = cs;
    bus.im_consumed_bank  = cbk;
    #1;

    g = -1;
    for (int k = 0; k < 3; k++) begin
      i = (m_rr + k) % 3;
      if (g < 0 && en && v[i] && m_st[i][m_cb[i]] != 2) g = i;
    end
    e_ready = 3'b000;
    if (g >= 0) e_ready[g] = 1'b1;
    check("src_ready", 64'(bus.src_ready), 64'(e_ready));

    e_err = 1'b0;
    if (cv) begin
      if (cs != 2'd3 && m_st[cs][cbk] == 2) m_st[cs][cbk] = 0;
      else e_err = 1'b1;
    end

    e_wr = 1'b0; e_av = 1'b0;
    e_src = 0; e_bank = 0; e_addr = 0; e_cnt = 0; e_data = '0;
    if (g >= 0) begin
      sh     = r >> (g * DW);
      e_data = sh[DW-1:0];
      e_wr   = 1'b1;
      e_src  = g;
      e_bank = m_cb[g];
      e_addr = m_wp[g];
      done   = l[g] || (m_wp[g] == DEPTH - 1);
      e_av   = done;
      e_cnt  = m_wp[g] + 1;
      if (done) begin
        m_st[g][m_cb[g]] = 2;
        m_wp[g] = 0;
        m_cb[g] = 1 - m_cb[g];
      end else begin
        m_st[g][m_cb[g]] = 1;
        m_wp[g] = m_wp[g] + 1;
      end
      m_rr = (g + 1) % 3;
    end

    @(posedge clk);
    #1;
    check("wr_en", 64'(bus.im_wr_en), 64'(e_wr));
    if (e_wr) begin
      check("wr_src",  64'(bus.im_wr_src),  64'(e_src));
      check("wr_bank", 64'(bus.im_wr_bank), 64'(e_bank));
      check("wr_addr", 64'(bus.im_wr_addr), 64'(e_addr));
      check("wr_data", 64'(bus.im_wr_data), 64'(e_data));
    end
    check("avail_valid", 64'(bus.im_avail_valid), 64'(e_av));
    if (e_av) begin
      check("avail_src",   64'(bus.im_avail_src),   64'(e_src));
      check("avail_bank",  64'(bus.im_avail_bank),  64'(e_bank));
      check("avail_count", 64'(bus.im_avail_count), 64'(e_cnt));
    end
    check("err_bad_consume", 64'(bus.err_bad_consume), 64'(e_err));
  endtask

  initial begin
    rst = 1'b0;
    do_reset();

    // xpd alone: one bank of 4 words, then the first word of bank 1
    repeat (5) cycle(1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);

    // All sources continuously valid: strict rotation from xpd
    do_reset();
    repeat (9) cycle(1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b0);

    // lz77d fills both banks and stalls; release bank 0 and resume there
    do_reset();
    repeat (11) cycle(1'b1, 3'b010, 3'b000, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 3'b010, 3'b000, 1'b1, 2'd1, 1'b0);
    repeat (2) cycle(1'b1, 3'b010, 3'b000, 1'b0, 2'd0, 1'b0);
    // release bank 1 while writing bank 0 of the same source
    cycle(1'b1, 3'b010, 3'b000, 1'b1, 2'd1, 1'b1);

    // htf_bl early close with src_last on the 2nd word
    do_reset();
    cycle(1'b1, 3'b100, 3'b000, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 3'b100, 3'b100, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 3'b100, 3'b000, 1'b0, 2'd0, 1'b0);

    // Illegal releases: free bank, then src 3, then a filling bank
    cycle(1'b1, 3'b000, 3'b000, 1'b1, 2'd0, 1'b1);
    cycle(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 3'b000, 3'b000, 1'b1, 2'd3, 1'b0);
    cycle(1'b1, 3'b000, 3'b000, 1'b1, 2'd2, 1'b1);
    cycle(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);

    // enable dropped after 2 words, then resumed at address 2
    do_reset();
    repeat (2) cycle(1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (3) cycle(1'b0, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);
    repeat (2) cycle(1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);

    // Reset mid-bank, capture restarts at bank 0 address 0
    repeat (2) cycle(1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);
    do_reset();
    repeat (2) cycle(1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [2:0] rl;
      rl = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b000;
      cycle(($urandom_range(0, 7) != 0), 3'($urandom()), rl,
            ($urandom_range(0, 2) == 0), 2'($urandom()), 1'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
